// File: rtl/prefetch_fifo_rr_drain_arb.sv
// prefetch_fifo_rr_drain_arb: round-robin burst drain of N_CH prefetch FIFOs (ch_en/ch_rd_vld/ch_rd_data in, ch_rd_en out) into one registered channel-tagged stream (out_data/out_ch/out_last/out_vld, out_rdy in), busy while bursting
module prefetch_fifo_rr_drain_arb #(
  parameter int N_CH = 4,
  parameter int DATA_W = 16,
  parameter int BURST_LEN = 8,
  parameter int CH_W = $clog2(N_CH),
  parameter int CNT_W = $clog2(BURST_LEN + 1)
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          ch_rd_vld,
  input  logic [N_CH*DATA_W-1:0]   ch_rd_data,
  output logic [N_CH-1:0]          ch_rd_en,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0] state;
  logic [CH_W-1:0] gnt, last_gnt, pick;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0][CH_W-1:0] cand;
  logic [DATA_W-1:0] dat [N_CH];
  logic load, pop, last_word;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign dat[i] = ch_rd_data[i*DATA_W +: DATA_W];
    assign cand[i] = CH_W'((int'(last_gnt) + 1 + i) % N_CH);
  end
  assign req = ch_rd_vld & ch_en;
  assign load = ~out_vld | out_rdy;
  assign busy = state == BURST;
  assign pop = busy & load & ch_rd_vld[gnt];
  assign last_word = cnt == CNT_W'(BURST_LEN - 1);
  always_comb begin
    ch_rd_en = '0;
    ch_rd_en[gnt] = pop;
  end
  always_comb begin
    pick = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      pick = req[cand[k]] ? cand[k] : pick;
  end
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= IDLE;
      gnt <= '0;
      last_gnt <= CH_W'(N_CH - 1);
      cnt <= '0;
      out_vld <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
    end else begin
      if (!busy && |req) begin
        state <= BURST;
        gnt <= pick;
        last_gnt <= pick;
        cnt <= '0;
      end else if (busy && load && (!ch_rd_vld[gnt] || last_word)) begin
        state <= IDLE;
      end
      if (pop) begin
        cnt <= cnt + CNT_W'(1);
        out_data <= dat[gnt];
        out_ch <= gnt;
        out_vld <= 1'b1;
        out_last <= last_word;
      end else if (load) begin
        out_vld <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prefetch_fifo_rr_drain_arb.sv
// tb_prefetch_fifo_rr_drain_arb: self-checking bench for prefetch_fifo_rr_drain_arb
module tb_prefetch_fifo_rr_drain_arb;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b0;
  logic [3:0] ch_en, ch_rd_vld, ch_rd_en;
  logic [63:0] ch_rd_data;
  logic [15:0] out_data;
  logic [1:0] out_ch;
  logic out_last, out_vld, out_rdy, busy;
  always #5 rd_clk = ~rd_clk;
  prefetch_fifo_rr_drain_arb #(.N_CH(4), .DATA_W(16), .BURST_LEN(8)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .ch_en(ch_en), .ch_rd_vld(ch_rd_vld),
    .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy)
  );
  typedef struct {
    logic [3:0] en;
    logic [31:0] av;
    int n;
    logic [5:0][3:0] gch;
    logic [5:0][3:0] glen;
    logic [5:0] glast;
  } vec_t;
  vec_t vecs [6];
  int checks = 0, errors = 0;
  int av [4];
  int seq [4];
  logic [17:0] sb [$];
  int b_ch [$], b_len [$], b_last [$];
  int cur_len, cur_ch, words;
  logic [3:0] popmask;
  bit bp, stalled;
  logic [15:0] pd;
  logic [1:0] pc;
  logic pl;
  logic s_busy, s_vld, s_last;
  logic [3:0] s_en;
  logic [1:0] s_ch;
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      ch_rd_vld[i] = av[i] != 0;
      ch_rd_data[i*16 +: 16] = {4'(i), 12'(seq[i])};
    end
  endtask
  task automatic close_burst(input int last);
    b_ch.push_back(cur_ch);
    b_len.push_back(cur_len);
    b_last.push_back(last);
    cur_len = 0;
  endtask
  task automatic clear_tb();
    sb.delete();
    b_ch.delete();
    b_len.delete();
    b_last.delete();
    cur_len = 0;
    words = 0;
    popmask = '0;
    stalled = 1'b0;
  endtask
  task automatic step();
    logic [3:0] pops;
    logic [17:0] exp;
    @(negedge rd_clk);
    s_busy = busy;
    s_vld = out_vld;
    s_last = out_last;
    s_ch = out_ch;
    s_en = ch_rd_en;
    if (stalled)
      chk(out_vld && out_data == pd && out_ch == pc && out_last == pl, "stall_hold",
          {out_vld, out_last, out_ch, out_data}, {1'b1, pl, pc, pd});
    if (out_vld && !out_rdy) chk(ch_rd_en == 4'b0, "rd_en_while_stalled", ch_rd_en, 0);
    chk($onehot0(ch_rd_en) && (ch_rd_en & ~ch_rd_vld) == 4'b0, "rd_en_legal", ch_rd_en, ch_rd_vld);
    if (out_vld && out_rdy) begin
      if (cur_len > 0 && int'(out_ch) != cur_ch) close_burst(0);
      if (sb.size() == 0) chk(1'b0, "sb_underflow", {out_ch, out_data}, 0);
      else begin
        exp = sb.pop_front();
        chk({out_ch, out_data} == exp, "word", {out_ch, out_data}, exp);
      end
      words++;
      cur_len++;
      cur_ch = int'(out_ch);
      if (out_last) close_burst(1);
    end else if (!out_vld && cur_len > 0) close_burst(0);
    for (int i = 0; i < 4; i++)
      if (ch_rd_en[i]) sb.push_back({2'(i), 4'(i), 12'(seq[i])});
    popmask |= ch_rd_en;
    pops = ch_rd_en;
    stalled = out_vld && !out_rdy;
    pd = out_data;
    pc = out_ch;
    pl = out_last;
    @(posedge rd_clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pops[i]) begin
        seq[i]++;
        if (av[i] > 0) av[i]--;
      end
    if (bp) out_rdy = 1'($urandom_range(0, 1));
    drive();
  endtask
  task automatic do_reset();
    rd_rst = 1'b1;
    #1;
    chk(!out_vld && !out_last && !busy, "reset_flags", {out_vld, out_last, busy}, 0);
    chk(out_data == 16'h0 && out_ch == 2'd0, "reset_data", {out_ch, out_data}, 0);
    chk(ch_rd_en == 4'b0, "reset_rd_en", ch_rd_en, 0);
    clear_tb();
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
  endtask
  initial begin
    vecs[0] = '{4'hF, 32'h0000FF00, 3, 24'h000111, 24'h000888, 6'b000111};
    vecs[1] = '{4'hF, 32'hFFFFFFFF, 5, 24'h003210, 24'h088888, 6'b011111};
    vecs[2] = '{4'h9, 32'hFFFFFFFF, 4, 24'h003030, 24'h008888, 6'b001111};
    vecs[3] = '{4'hF, 32'hFF030000, 3, 24'h000332, 24'h000883, 6'b000110};
    vecs[4] = '{4'h6, 32'hFFFFFFFF, 3, 24'h000121, 24'h000888, 6'b000111};
    vecs[5] = '{4'h0, 32'hFFFFFFFF, 0, 24'h0, 24'h0, 6'b0};
    for (int i = 0; i < 4; i++) begin
      av[i] = 0;
      seq[i] = 0;
    end
    ch_en = 4'h0;
    out_rdy = 1'b1;
    bp = 1'b0;
    drive();
    #3;
    do_reset();
    ch_en = 4'hF;
    av[1] = -1;
    drive();
    for (int k = 1; k <= 28; k++) begin
      int c;
      bit ev;
      step();
      c = k - 1;
      ev = c >= 2 && ((c - 2) % 9) != 8;
      chk(s_busy == (c >= 1 && ((c - 1) % 9) != 8), "busy_timing", s_busy, c);
      chk(s_vld == ev, "vld_timing", s_vld, c);
      if (k == 2) chk(s_en == 4'b0010, "first_rd_en", s_en, 4'b0010);
      if (ev) chk(s_ch == 2'd1 && s_last == (((c - 2) % 9) == 7), "tag_last", {s_ch, s_last}, c);
    end
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ch_en = vecs[v].en;
      for (int i = 0; i < 4; i++)
        av[i] = vecs[v].av[i*8 +: 8] == 8'hFF ? -1 : int'(vecs[v].av[i*8 +: 8]);
      drive();
      for (int c = 0; c < (vecs[v].n == 0 ? 40 : 300); c++) begin
        if (vecs[v].n > 0 && b_ch.size() >= vecs[v].n) break;
        step();
      end
      chk(b_ch.size() >= vecs[v].n, "burst_count", b_ch.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < b_ch.size(); k++)
        chk(b_ch[k] == int'(vecs[v].gch[k]) && b_len[k] == int'(vecs[v].glen[k]) &&
            b_last[k] == int'(vecs[v].glast[k]), "burst",
            {b_ch[k][7:0], b_len[k][7:0], b_last[k][7:0]},
            {8'(vecs[v].gch[k]), 8'(vecs[v].glen[k]), 7'd0, vecs[v].glast[k]});
      chk((popmask & ~vecs[v].en) == 4'b0, "masked_pop", popmask, vecs[v].en);
      if (vecs[v].n == 0) chk(words == 0 && !out_vld, "idle_no_words", words, 0);
    end
    do_reset();
    ch_en = 4'hF;
    for (int i = 0; i < 4; i++) av[i] = -1;
    drive();
    bp = 1'b1;
    repeat (300) step();
    bp = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) av[i] = 0;
    drive();
    for (int c = 0; c < 60 && (sb.size() > 0 || out_vld); c++) step();
    chk(sb.size() == 0 && !out_vld, "bp_drain", sb.size(), 0);
    chk(words >= 40, "bp_progress", words, 40);
    do_reset();
    ch_en = 4'hF;
    av[2] = -1;
    drive();
    for (int c = 0; c < 60 && !(cur_len == 4 && cur_ch == 2); c++) step();
    chk(cur_len == 4 && cur_ch == 2 && s_vld, "reached_word4", {cur_ch[7:0], cur_len[7:0]}, 16'h0204);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) av[i] = -1;
    drive();
    for (int c = 0; c < 60 && b_ch.size() < 1; c++) step();
    chk(b_ch.size() >= 1 && b_ch[0] == 0, "grant_after_reset", b_ch.size() >= 1 ? b_ch[0] : -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
